uart_tx_drain: RTL
==================

Name: uart_tx_drain

Overview:
Serial transmit stage that sits directly downstream of the 16x8 byte FIFO. It pulls one byte at a time through the FIFO's read strobe and empty flag. Each byte is shifted out LSB-first as an asynchronous serial frame: start bit, 8 data bits, stop bit. The block is the off-chip exit point for FIFO-buffered data.

Parameters:
CLK_DIV, 434, clocks per serial bit (50 MHz / 115200); legal range 2..65535
CNT_W, 16, width of the bit-period counter; must hold CLK_DIV-1

Ports:
ck  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
fifo_empty  input  1  FIFO empty flag (registered in FIFO)
fifo_dout  input  8  FIFO read data; valid the cycle after fifo_ren is sampled high
fifo_ren  output  1  FIFO read strobe, single-cycle pulse
txd  output  1  serial line, idle high
busy  output  1  high from read request until end of stop bit

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE, txd=1, busy=0, bit counter=0, bit index=0, shift register=0. fifo_ren=0 while in reset.
- Reset mid-frame: txd returns to 1 on the next edge. The byte in flight is dropped. The FIFO is not re-read for it.
- fifo_ren is combinational: fifo_ren = (state==IDLE) && !fifo_empty && rst. It is high for at most one cycle per byte.
- States: IDLE, WAIT, START, DATA, STOP (PARITY when enabled).
- IDLE: txd=1, busy=0. If fifo_empty==0, go to WAIT (fifo_ren high this cycle).
- WAIT (1 clock): busy=1, txd=1. fifo_dout is now valid; latch it into the shift register. Go to START.
- START: txd=0 for CLK_DIV clocks, then go to DATA with bit index=0.
- DATA: txd=shift[0] for CLK_DIV clocks per bit, then shift right. After bit index 7 completes, go to STOP.
- STOP: txd=1 for CLK_DIV clocks, then go to IDLE.
- Bit counter counts 0..CLK_DIV-1; the bit boundary is at CLK_DIV-1. The counter clears on every state change.
- Frame length is exactly 10*CLK_DIV clocks from START entry to IDLE entry.
- Back-to-back bytes: the minimum idle-high gap after the stop bit is 2 clocks (IDLE + WAIT).
- fifo_empty is ignored outside IDLE. A byte written to the FIFO mid-frame is read only after STOP.
- No data arithmetic is performed; all counters wrap only via explicit clear.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. txd = XOR of the 8 data bits (even parity) for CLK_DIV clocks. Frame length becomes 11*CLK_DIV.
- Undefined: no PARITY state and no parity logic; frame length is 10*CLK_DIV.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, WAIT, START, DATA, STOP, PARITY), DATA_BITS=8 constant, IDLE_LEVEL=1'b1 constant.
- Sub-module uart_baud_cnt: a CNT_W-bit counter with a clear input and a tick output asserted at CLK_DIV-1. This counter is reused by the future receiver.

Test Plan (CLK_DIV=4 unless stated):
- Reset: hold rst=0 for 3 clocks with fifo_empty=0 -> txd=1, busy=0, fifo_ren=0 throughout.
- Single byte 0xA5: fifo_empty falls for one read -> exactly one fifo_ren pulse. txd = 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks (40 clocks total). busy is high from WAIT through the end of STOP.
- Back-to-back 0x00 then 0xFF from the FIFO -> exactly 2 fifo_ren pulses. There are 2 idle-high clocks between the first stop bit ending and the second start bit. Second frame data bits are all 1.
- Reset mid-frame: assert rst=0 during data bit 3 of 0x3C -> txd=1 on the next edge. No fifo_ren while rst=0. After release, the next FIFO byte is sent as a full, clean frame.
- Empty FIFO: fifo_empty held 1 for 1000 clocks -> fifo_ren never high, txd constant 1, busy constant 0.
- With UART_TX_PARITY_EN, byte 0x07 -> parity bit 1 between data bit 7 and stop. Frame is 44 clocks. Byte 0x03 gives parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit and (future) receive paths.
//   state_t    : serializer states, PARITY is only reachable when the
//                parity option (UART_TX_PARITY_EN) is compiled in
//   DATA_BITS  : payload bits per frame
//   IDLE_LEVEL : level of the serial line between frames
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd4,
        PARITY = 3'd5
    } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLK_DIV-1; never wraps on its own, the owner clears it.
// Parameters:
//   CLK_DIV : clocks per serial bit (2..65535)
//   CNT_W   : counter width, must hold CLK_DIV-1
// Ports:
//   ck     in  system clock, rising edge
//   rst    in  synchronous reset, active-low
//   i_clr  in  clear counter to 0 on the next edge
//   o_tick out high while the counter sits at CLK_DIV-1 (bit boundary)
module uart_baud_cnt #(
    parameter int CLK_DIV = 434,
    parameter int CNT_W   = 16
) (
    input  logic ck,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge ck) begin
        if (!rst || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain
// Serial transmit stage fed by the 16x8 byte FIFO. Pops one byte at a time
// and shifts it out LSB-first as start bit, 8 data bits, stop bit.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit (frame 11 bit periods instead of 10).
// Parameters:
//   CLK_DIV : clocks per serial bit (default 434 = 50 MHz / 115200)
//   CNT_W   : bit-period counter width, must hold CLK_DIV-1
// Ports:
//   ck         in  system clock, rising edge
//   rst        in  synchronous reset, active-low
//   fifo_empty in  FIFO empty flag
//   fifo_dout  in  FIFO read data, valid the cycle after fifo_ren
//   fifo_ren   out FIFO read strobe, one-cycle pulse per byte
//   txd        out serial line, idle high
//   busy       out high from the read request until the stop bit ends
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int CNT_W   = 16
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_dout,
    output logic                 fifo_ren,
    output logic                 txd,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 w_tick;
    logic                 w_cnt_clr;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_last_bit;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    // The counter is held at zero while no bit is being timed, so START
    // always begins at count 0; at each bit boundary it is cleared again.
    uart_baud_cnt #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_baud_cnt (
        .ck     (ck),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .o_tick (w_tick)
    );

    assign w_last_bit = (r_bit_idx == IDX_W'(DATA_BITS - 1));

    always_ff @(posedge ck) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_load) begin
            r_shift   <= fifo_dout;
            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            // Captured at load time because the shift register is consumed.
            r_parity  <= ^fifo_dout;
`endif
        end else if (w_shift) begin
            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= w_last_bit ? '0 : r_bit_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        fifo_ren    = 1'b0;
        txd         = IDLE_LEVEL;
        busy        = 1'b1;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_cnt_clr   = 1'b0;

        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                w_cnt_clr = 1'b1;
                // rst gates the strobe so the FIFO is never popped in reset.
                if (!fifo_empty && rst) begin
                    fifo_ren    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                // FIFO read data arrives this cycle.
                w_cnt_clr   = 1'b1;
                w_load      = 1'b1;
                w_state_nxt = START;
            end
            START: begin
                txd = 1'b0;
                if (w_tick) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                txd = r_shift[0];
                if (w_tick) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd = r_parity;
                if (w_tick) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                busy        = 1'b0;
                w_cnt_clr   = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
